// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Round-robin sharing of one HWPE peripheral configuration port with an offload critical-section lock.
// Optional forced release of an idle owner's lock is enabled by defining HWPE_ARB_LOCK_TIMEOUT_EN.
module hwpe_ctrl_periph_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned REG_IDX_W  = 5,
  parameter logic [DATA_WIDTH-1:0] BUSY_VAL = 32'hFFFF_FFFF
`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
  ,
  parameter int unsigned LOCK_TIMEOUT = 1024
`endif
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]     add_i,
  input  logic [N_REQ-1:0]                wen_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]   be_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]     data_i,
  input  logic [N_REQ*ID_WIDTH-1:0]       id_i,
  output logic [N_REQ-1:0]                gnt_o,
  output logic [DATA_WIDTH-1:0]           r_data_o,
  output logic [N_REQ-1:0]                r_valid_o,
  output logic                            m_req_o,
  output logic [ADDR_WIDTH-1:0]           m_add_o,
  output logic                            m_wen_o,
  output logic [DATA_WIDTH/8-1:0]         m_be_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic [ID_WIDTH-1:0]             m_id_o,
  input  logic                            m_gnt_i,
  input  logic [DATA_WIDTH-1:0]           m_r_data_i,
  input  logic                            m_r_valid_i,
  output logic                            locked_o,
  output logic [$clog2(N_REQ)-1:0]        owner_o
`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
  ,
  output logic                            timeout_o
`endif
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQ_PEND = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     resp_idx_q, resp_idx_d;
  logic [IDX_W-1:0]     sel_s;
  logic [N_REQ-1:0]     elig_s;
  logic [N_REQ-1:0]     owner_mask_s;
  logic                 accept_s;
  logic                 timeout_s;
  logic [REG_IDX_W-1:0] reg_idx_s;

  // First eligible core at or after ptr, wrapping; scanned backwards so the lowest offset wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [IDX_W-1:0] ptr);
    int c;
    rr_pick = ptr;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % int'(N_REQ);
      if (elig[IDX_W'(c)]) rr_pick = IDX_W'(c);
      else rr_pick = rr_pick;
    end
  endfunction

  always_comb begin
    owner_mask_s = '0;
    owner_mask_s[owner_q] = 1'b1;
    if (state_q == UNLOCKED) elig_s = req_i;
    else elig_s = req_i & owner_mask_s;
  end

  assign sel_s     = rr_pick(elig_s, rr_ptr_q);
  assign m_req_o   = |elig_s;
  assign accept_s  = m_req_o & m_gnt_i;
  assign reg_idx_s = m_add_o[REG_IDX_W+1:2];

  always_comb begin
    m_add_o  = '0;
    m_wen_o  = 1'b0;
    m_be_o   = '0;
    m_data_o = '0;
    m_id_o   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      m_add_o  |= add_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{sel_s == IDX_W'(i)}};
      m_wen_o  |= wen_i[i] & (sel_s == IDX_W'(i));
      m_be_o   |= be_i[i*BE_W +: BE_W] & {BE_W{sel_s == IDX_W'(i)}};
      m_data_o |= data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_s == IDX_W'(i)}};
      m_id_o   |= id_i[i*ID_WIDTH +: ID_WIDTH] & {ID_WIDTH{sel_s == IDX_W'(i)}};
    end
  end

  always_comb begin
    gnt_o            = '0;
    gnt_o[sel_s]     = accept_s;
    r_valid_o        = '0;
    r_valid_o[resp_idx_q] = m_r_valid_i;
  end

  assign r_data_o = m_r_data_i;
  assign locked_o = (state_q == LOCKED);
  assign owner_o  = owner_q;

`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Idle time of the owner; any accepted owner transaction restarts it.
  always_comb begin
    if (state_q != LOCKED || accept_s) cnt_d = '0;
    else cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign timeout_s = (state_q == LOCKED) && !accept_s && (cnt_q == CNT_W'(LOCK_TIMEOUT));
  assign timeout_o = timeout_s;
`else
  assign timeout_s = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    resp_idx_d = resp_idx_q;
    if (accept_s) begin
      rr_ptr_d   = (sel_s == IDX_W'(N_REQ - 1)) ? '0 : sel_s + IDX_W'(1);
      resp_idx_d = sel_s;
    end else begin
      rr_ptr_d   = rr_ptr_q;
      resp_idx_d = resp_idx_q;
    end
    // Clear still lets the routing update above go through so in-flight responses land.
    if (clear_i) begin
      state_d = UNLOCKED;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (accept_s && m_wen_o && reg_idx_s == REG_IDX_W'(1)) begin
            state_d = ACQ_PEND;
            owner_d = sel_s;
          end else begin
            state_d = UNLOCKED;
          end
        end
        ACQ_PEND: begin
          if (m_r_data_i != BUSY_VAL) state_d = LOCKED;
          else state_d = UNLOCKED;
        end
        LOCKED: begin
          if (accept_s && !m_wen_o &&
              (reg_idx_s == REG_IDX_W'(0) || reg_idx_s == REG_IDX_W'(5))) state_d = UNLOCKED;
          else if (timeout_s) state_d = UNLOCKED;
          else state_d = LOCKED;
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UNLOCKED;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      resp_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      resp_idx_q <= resp_idx_d;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// Directed and random checks of hwpe_ctrl_periph_arbiter against a transaction-level reference model.
module tb_hwpe_ctrl_periph_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int BW = 4;
  localparam logic [31:0] BUSY = 32'hFFFF_FFFF;
`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
  localparam int TMO = 8;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] add_i;
  logic [N-1:0]    wen_i;
  logic [N*BW-1:0] be_i;
  logic [N*DW-1:0] data_i;
  logic [N*IW-1:0] id_i;
  logic [N-1:0]    gnt_o;
  logic [DW-1:0]   r_data_o;
  logic [N-1:0]    r_valid_o;
  logic            m_req_o;
  logic [AW-1:0]   m_add_o;
  logic            m_wen_o;
  logic [BW-1:0]   m_be_o;
  logic [DW-1:0]   m_data_o;
  logic [IW-1:0]   m_id_o;
  logic            m_gnt_i;
  logic [DW-1:0]   m_r_data_i;
  logic            m_r_valid_i;
  logic            locked_o;
  logic [1:0]      owner_o;
`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
  logic            timeout_o;
`endif

  hwpe_ctrl_periph_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .REG_IDX_W(5)
`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
    , .LOCK_TIMEOUT(TMO)
`endif
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .id_i(id_i),
    .gnt_o(gnt_o), .r_data_o(r_data_o), .r_valid_o(r_valid_o),
    .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_be_o(m_be_o),
    .m_data_o(m_data_o), .m_id_o(m_id_o),
    .m_gnt_i(m_gnt_i), .m_r_data_i(m_r_data_i), .m_r_valid_i(m_r_valid_i),
    .locked_o(locked_o), .owner_o(owner_o)
`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Per-core stimulus for the coming cycle
  logic        s_req [N];
  logic [31:0] s_add [N];
  logic        s_wen [N];
  logic [31:0] s_data[N];
  logic [15:0] s_id  [N];
  logic [3:0]  s_be  [N];
  logic        s_clear, s_mgnt, s_fix_en;
  logic [31:0] s_fix_data;

  // Reference model: lock mode 0=free 1=acquire pending 2=held
  int          m_state, m_owner, m_ptr, m_sel, m_cnt, pend_core;
  bit          m_acc, pend_valid;
  logic [31:0] pend_data, drv_rdata;

  logic [N-1:0] obs_gnt;
  logic         obs_locked, obs_timeout;
  logic [1:0]   obs_owner;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_ord[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_clr[3] = '{4'b0010, 4'b0100, 4'b1000};
  int         idx_tab[4] = '{0, 1, 2, 5};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int c, input logic rq, input logic wn, input int idx);
    s_req[c]  = rq;
    s_wen[c]  = wn;
    s_add[c]  = ($urandom() & 32'hFFFF_FF80) | (32'(idx) << 2);
    s_data[c] = $urandom();
    s_id[c]   = 16'($urandom());
    s_be[c]   = 4'($urandom());
  endtask

  task automatic cycle();
    logic [N-1:0] exp_gnt, exp_rv;
    int idx, nstate;
    bit exp_to;
    @(negedge clk_i);
    for (int c = 0; c < N; c++) begin
      req_i[c]             = s_req[c];
      wen_i[c]             = s_wen[c];
      add_i[c*AW +: AW]    = s_add[c];
      data_i[c*DW +: DW]   = s_data[c];
      id_i[c*IW +: IW]     = s_id[c];
      be_i[c*BW +: BW]     = s_be[c];
    end
    clear_i     = s_clear;
    m_gnt_i     = s_mgnt;
    drv_rdata   = pend_valid ? pend_data : 32'($urandom());
    m_r_valid_i = pend_valid;
    m_r_data_i  = drv_rdata;
    #1;
    m_sel = -1;
    for (int off = 0; off < N; off++) begin
      int c;
      c = (m_ptr + off) % N;
      if (m_sel < 0 && s_req[c] && (m_state == 0 || c == m_owner)) m_sel = c;
    end
    m_acc   = (m_sel >= 0) && s_mgnt;
    exp_gnt = m_acc ? (4'b0001 << m_sel) : 4'b0000;
    exp_rv  = pend_valid ? (4'b0001 << pend_core) : 4'b0000;
    exp_to  = 1'b0;
`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
    exp_to  = (m_state == 2) && (m_cnt == TMO) && !m_acc;
    chk("timeout", timeout_o, exp_to);
    obs_timeout = timeout_o;
`endif
    chk("gnt", gnt_o, exp_gnt);
    chk("m_req", m_req_o, m_sel >= 0);
    chk("r_valid", r_valid_o, exp_rv);
    chk("r_data", r_data_o, drv_rdata);
    chk("locked", locked_o, m_state == 2);
    chk("owner", owner_o, m_owner);
    if (m_sel >= 0) begin
      chk("m_fields", {m_add_o, m_wen_o, m_be_o, m_id_o},
          {s_add[m_sel], s_wen[m_sel], s_be[m_sel], s_id[m_sel]});
      chk("m_data", m_data_o, s_data[m_sel]);
    end
    obs_gnt    = gnt_o;
    obs_locked = locked_o;
    obs_owner  = owner_o;
    @(posedge clk_i);
    idx    = (m_sel >= 0) ? int'((s_add[m_sel] >> 2) & 32'h1F) : 0;
    nstate = m_state;
    if (m_state == 0 && m_acc && s_wen[m_sel] && idx == 1) begin
      nstate  = 1;
      m_owner = m_sel;
    end else if (m_state == 1) begin
      nstate = (drv_rdata != BUSY) ? 2 : 0;
    end else if (m_state == 2 && m_acc && !s_wen[m_sel] && (idx == 0 || idx == 5)) begin
      nstate = 0;
    end else if (exp_to) begin
      nstate = 0;
    end
    if (s_clear) nstate = 0;
    if (m_state != 2 || m_acc) m_cnt = 0;
    else m_cnt++;
    m_state = nstate;
    if (m_acc) begin
      m_ptr     = (m_sel + 1) % N;
      pend_core = m_sel;
    end
    pend_valid = m_acc;
    pend_data  = s_fix_en ? s_fix_data : 32'($urandom());
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; req_i = '0; add_i = '0; wen_i = '0; be_i = '0;
    data_i = '0; id_i = '0; m_gnt_i = 1'b0; m_r_data_i = '0; m_r_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_locked", locked_o, 1'b0);
    chk("rst_owner", owner_o, 2'd0);
    chk("rst_r_valid", r_valid_o, 4'b0000);
    chk("rst_gnt_mreq", {gnt_o, m_req_o}, 5'b00000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_state = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; pend_core = 0; pend_valid = 1'b0;
    pend_data = '0;
    for (int c = 0; c < N; c++) set_core(c, 1'b0, 1'b1, 2);
    s_clear = 1'b0; s_mgnt = 1'b1; s_fix_en = 1'b0; s_fix_data = '0;
    cycle();

    // All cores stream reads of register 2
    for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b1, 2);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_order", obs_gnt, exp_ord[k]);
    end

    // Core 1 acquires, core 2 waits until the trigger write
    set_core(0, 1'b0, 1'b1, 2); set_core(3, 1'b0, 1'b1, 2);
    set_core(1, 1'b1, 1'b1, 1); set_core(2, 1'b1, 1'b1, 2);
    s_fix_en = 1'b1; s_fix_data = 32'h0000_0000;
    cycle(); chk("acq_gnt", obs_gnt, 4'b0010);
    set_core(1, 1'b0, 1'b1, 2); s_fix_en = 1'b0;
    cycle(); chk("pend_no_gnt", obs_gnt, 4'b0000);
    set_core(1, 1'b1, 1'b0, 3);
    repeat (2) begin
      cycle();
      chk("lock_held", {obs_locked, obs_owner}, 3'b101);
      chk("lock_block", obs_gnt, 4'b0010);
    end
    set_core(1, 1'b1, 1'b0, 0);
    cycle(); chk("trigger_gnt", obs_gnt, 4'b0010);
    set_core(1, 1'b0, 1'b1, 2);
    cycle(); chk("release", {obs_locked, obs_gnt}, 5'b00100);

    // Busy acquire by core 3 never locks
    set_core(2, 1'b0, 1'b1, 2); set_core(3, 1'b1, 1'b1, 1);
    s_fix_en = 1'b1; s_fix_data = BUSY;
    cycle(); chk("busy_acq_gnt", obs_gnt, 4'b1000);
    set_core(3, 1'b0, 1'b1, 2); s_fix_en = 1'b0;
    repeat (3) begin
      cycle(); chk("busy_unlocked", obs_locked, 1'b0);
    end

    // Core 0 locks, clear_i drops the lock, others resume round-robin
    set_core(0, 1'b1, 1'b1, 1); s_fix_en = 1'b1; s_fix_data = 32'h0000_0003;
    cycle(); chk("d_acq", obs_gnt, 4'b0001);
    set_core(0, 1'b0, 1'b1, 2); s_fix_en = 1'b0;
    for (int c = 1; c < N; c++) set_core(c, 1'b1, 1'b1, 2);
    cycle(); chk("d_pend", obs_gnt, 4'b0000);
    s_clear = 1'b1;
    cycle(); chk("d_locked", {obs_locked, obs_gnt}, 5'b10000);
    s_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(); chk("clear_rr", {obs_locked, obs_gnt}, {1'b0, exp_clr[k]});
    end

    // Slave stalls for 3 cycles with cores 0 and 2 requesting
    set_core(1, 1'b0, 1'b1, 2); set_core(3, 1'b0, 1'b1, 2);
    set_core(0, 1'b1, 1'b1, 2); set_core(2, 1'b1, 1'b1, 2);
    s_mgnt = 1'b0;
    repeat (3) begin
      cycle(); chk("stall_gnt", obs_gnt, 4'b0000);
    end
    s_mgnt = 1'b1;
    cycle(); chk("stall_rel0", obs_gnt, 4'b0001);
    cycle(); chk("stall_rel2", obs_gnt, 4'b0100);

`ifdef HWPE_ARB_LOCK_TIMEOUT_EN
    for (int c = 0; c < N; c++) set_core(c, 1'b0, 1'b1, 2);
    set_core(2, 1'b1, 1'b1, 1); s_fix_en = 1'b1; s_fix_data = 32'h0;
    cycle(); chk("to_acq", obs_gnt, 4'b0100);
    set_core(2, 1'b0, 1'b1, 2); s_fix_en = 1'b0;
    repeat (9) begin
      cycle(); chk("to_quiet", obs_timeout, 1'b0);
    end
    cycle(); chk("to_pulse", {obs_timeout, obs_locked}, 2'b11);
    cycle(); chk("to_release", {obs_timeout, obs_locked}, 2'b00);
`endif

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < N; c++)
        set_core(c, ($urandom() % 2) == 1, ($urandom() % 2) == 1, idx_tab[$urandom() % 4]);
      s_mgnt     = ($urandom() % 4) != 0;
      s_clear    = ($urandom() % 40) == 0;
      s_fix_en   = 1'b1;
      s_fix_data = (($urandom() % 3) == 0) ? BUSY : 32'($urandom());
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_periph_arbiter.md
Name: hwpe_ctrl_periph_arbiter

Overview:
- Shares the single peripheral configuration port of an HWPE control slave among N_REQ cores.
- Round-robin arbitration, one transaction per cycle, with responses routed back to the issuing core.
- Holds an exclusive lock over the offload critical section: from a successful acquire read (register 1) until the owner's trigger write (register 0), a soft-clear write (register 5), or an external clear.
- Prevents cores from interleaving job-register writes.

Parameters:
- N_REQ, 4, number of requesting cores (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- ID_WIDTH, 16, requester ID width.
- REG_IDX_W, 5, width of the word register index taken from add[REG_IDX_W+1:2].
- BUSY_VAL, 32'hFFFF_FFFF, acquire read data meaning "no free context".
- LOCK_TIMEOUT, 1024, idle-owner cycles before forced release (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear, connected to the slave's clear output.
- req_i  in  N_REQ  per-core request.
- add_i  in  N_REQ x ADDR_WIDTH  per-core address.
- wen_i  in  N_REQ  per-core write-enable, 1 = read, 0 = write.
- be_i  in  N_REQ x DATA_WIDTH/8  per-core byte enables.
- data_i  in  N_REQ x DATA_WIDTH  per-core write data.
- id_i  in  N_REQ x ID_WIDTH  per-core ID.
- gnt_o  out  N_REQ  per-core grant, one-hot or zero.
- r_data_o  out  DATA_WIDTH  read data, broadcast to all cores.
- r_valid_o  out  N_REQ  per-core response valid.
- m_req_o, m_add_o, m_wen_o, m_be_o, m_data_o, m_id_o  out  slave-side request fields, same widths as the per-core fields.
- m_gnt_i  in  1  slave grant.
- m_r_data_i  in  DATA_WIDTH  slave read data.
- m_r_valid_i  in  1  slave response valid; arrives exactly 1 cycle after an accepted request.
- locked_o  out  1  lock held.
- owner_o  out  $clog2(N_REQ)  lock owner index.

Behaviour:
- Reset:
  - state UNLOCKED; rr_ptr=0; owner=0; resp_idx=0; resp_pend=0; timeout counter 0.
  - locked_o=0, owner_o=0, r_valid_o=0.
  - gnt_o=0 and m_req_o=0 whenever req_i=0.
- Eligible set:
  - UNLOCKED: all requesting cores.
  - ACQ_PEND or LOCKED: only the owner.
- Arbitration:
  - Combinational. Select the first eligible core at or after rr_ptr, wrapping modulo N_REQ.
  - m_* fields = the selected core's fields; m_req_o=1.
  - gnt_o[sel] = m_gnt_i.
  - On an accepted transaction (m_req_o & m_gnt_i): rr_ptr <= sel+1, with wrap (N_REQ-1 -> 0).
- Response routing:
  - On accept: resp_idx <= sel.
  - r_valid_o[resp_idx] = m_r_valid_i; all other bits 0.
  - r_data_o = m_r_data_i.
  - Latency: request accepted at cycle t, response at t+1. Back-to-back grants to different cores are allowed.
- Register index: idx = m_add_o[REG_IDX_W+1:2]. Context bits above idx are ignored for lock decode.
- Lock FSM:
  - UNLOCKED -> ACQ_PEND: accepted read (wen=1) with idx==1. owner <= sel.
  - ACQ_PEND (lasts exactly 1 cycle):
    - m_r_data_i != BUSY_VAL -> LOCKED.
    - m_r_data_i == BUSY_VAL -> UNLOCKED.
    - An owner request in this cycle is arbitrated normally.
  - LOCKED -> UNLOCKED: owner's accepted write (wen=0) with idx==0 (trigger) or idx==5 (soft clear). The release takes effect the next cycle, so other cores become eligible from cycle t+1.
  - In any state, clear_i=1 forces UNLOCKED next cycle. The response routing register is still updated, so an in-flight response is still delivered.
- locked_o = (state==LOCKED). owner_o = owner.
- Boundary cases:
  - Owner issues an acquire read while LOCKED: forwarded, no state change.
  - Non-owner requests while locked: gnt_o=0 and the request stays pending. No starvation after release, because rr_ptr was advanced past the owner.
  - m_gnt_i=0: no accept; rr_ptr, state and resp_idx are unchanged.

Optional Feature:
- Macro: HWPE_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(LOCK_TIMEOUT+1) bits resets to 0 on entering LOCKED and on every accepted owner transaction. Otherwise it increments while LOCKED.
  - At LOCK_TIMEOUT the lock is forced to UNLOCKED and a 1-cycle pulse is driven on output timeout_o.
- Not defined: no counter, no timeout_o port; the lock is held indefinitely.

Test Plan:
- Reset, then cores 0..3 all request reads of idx 2 continuously:
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Each r_valid_o bit fires 1 cycle after its grant with the matching r_data_o.
- Core 1 reads idx 1 and the slave returns 0:
  - locked_o=1, owner_o=1.
  - Core 2 keeps requesting and gnt_o[2]=0 throughout.
  - Core 1 writes idx 0: locked_o=0 next cycle and core 2 is granted that cycle.
- Core 3 reads idx 1 and the slave returns 32'hFFFF_FFFF: state returns to UNLOCKED after 1 cycle, locked_o never asserts.
- Locked by core 0, then clear_i pulses: locked_o=0 next cycle and cores 1..3 resume round-robin from rr_ptr.
- m_gnt_i held at 0 for 3 cycles while cores 0 and 2 request: gnt_o stays 0 and rr_ptr is unchanged; after release, grant order is 0 then 2.
- With HWPE_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=8: core 2 locks and then goes idle; timeout_o pulses 8 cycles later and locked_o drops.
